// File: rtl/dma_bus_pkg.sv
// Shared types, widths and address decode for the DMA bus target.
package dma_bus_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {StIdle, StWait, StBeat, StDrain} state_e;

   // True when addr falls in [base, base + 2**bits).
   function automatic logic addr_hit(input logic [ADDR_W-1:0] base, input int unsigned bits,
                                     input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] rel;
      rel = addr - base;
      return (addr >= base) && ((rel >> bits) == '0);
   endfunction

endpackage

// File: rtl/dma_target_ram.sv
// Word array behind the bus target: synchronous write, asynchronous read.
module dma_target_ram
   import dma_bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [DATA_W-1:0]    i_wdata,
   output logic [DATA_W-1:0]    o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_BITS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dma_bus_target.sv
// Memory-mapped responder on the DMA bus: decodes the address phase and serves
// single or burst reads/writes from a local array, pacing each beat with Ready.
module dma_bus_target
   import dma_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned       ADDR_BITS   = 8,
   parameter int unsigned       WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Address,
   inout  wire  [DATA_W-1:0] Data,
   input  logic              read,
   input  logic              write,
   input  logic              Frame,
   output logic              Ready
);

   localparam logic [3:0] WaitLast  = 4'(WAIT_STATES - 1);
   localparam state_e     BeatEntry = (WAIT_STATES == 0) ? StBeat : StWait;

   state_e               r_state;
   state_e               w_state_d;
   logic                 r_ready;
   logic                 r_cmd_rd;
   logic [ADDR_BITS-1:0] r_offset;
   logic [3:0]           r_wait_cnt;

   logic                 w_hit;
   logic                 w_addr_phase;
   logic                 w_last_wait;
   logic                 w_data_oe;
   logic                 w_mem_we;
   logic [ADDR_BITS-1:0] w_start_off;
   logic [DATA_W-1:0]    w_rd_data;

   // read == write (both or neither) is treated as a miss
   assign w_hit        = addr_hit(BASE_ADDR, ADDR_BITS, Address) && (read != write);
   assign w_addr_phase = (r_state == StIdle) && !Frame;
   assign w_start_off  = Address[ADDR_BITS-1:0] - BASE_ADDR[ADDR_BITS-1:0];
   assign w_last_wait  = (r_wait_cnt == WaitLast);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_ready <= (w_state_d == StBeat);
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (!Frame) w_state_d = w_hit ? BeatEntry : StDrain;
         StWait:  if (w_last_wait) w_state_d = StBeat;
         StBeat:  w_state_d = Frame ? StIdle : BeatEntry;
         StDrain: if (Frame) w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_data_oe = (r_state == StBeat) && r_cmd_rd;
      w_mem_we  = (r_state == StBeat) && !r_cmd_rd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_rd   <= 1'b0;
         r_offset   <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_addr_phase && w_hit) begin
            r_cmd_rd <= read;
            r_offset <= w_start_off;
         end else if ((r_state == StBeat) && !Frame) begin
            // wraps within the window
            r_offset <= r_offset + ADDR_BITS'(1);
         end
         if ((r_state == StWait) && !w_last_wait) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   dma_target_ram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .i_clk  (clk),
      .i_we   (w_mem_we),
      .i_addr (r_offset),
      .i_wdata(Data),
      .o_rdata(w_rd_data)
   );

   assign Ready = r_ready;
   assign Data  = w_data_oe ? w_rd_data : 'z;

endmodule

// File: tb/tb_dma_bus_target.sv
// Directed bench for dma_bus_target: one instance with one wait state, one with none,
// driven by a reactive bus initiator.
module tb_dma_bus_target;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        rd;
   logic        wr;
   logic        frame_a;
   logic        frame_b;
   logic        ready_a;
   logic        ready_b;
   logic        sel;
   logic        drv_en;
   logic [31:0] drv;
   wire  [31:0] data_a;
   wire  [31:0] data_b;
   wire  [31:0] data_in;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] rbuf [4];
   int          bt   [4];

   typedef struct {
      bit              sel;
      bit              wr;
      logic [31:0]     addr;
      int              nb;
      logic [3:0][31:0] d;
      int              lat;
   } vec_t;

   vec_t vecs [11];

   assign data_a  = (drv_en && !sel) ? drv : 'z;
   assign data_b  = (drv_en && sel) ? drv : 'z;
   assign data_in = sel ? data_b : data_a;

   dma_bus_target #(
      .BASE_ADDR  (32'h0000_1000),
      .ADDR_BITS  (8),
      .WAIT_STATES(1)
   ) u_dut_ws1 (
      .clk    (clk),
      .rst    (rst),
      .Address(addr),
      .Data   (data_a),
      .read   (rd),
      .write  (wr),
      .Frame  (frame_a),
      .Ready  (ready_a)
   );

   dma_bus_target #(
      .BASE_ADDR  (32'h0000_1000),
      .ADDR_BITS  (8),
      .WAIT_STATES(0)
   ) u_dut_ws0 (
      .clk    (clk),
      .rst    (rst),
      .Address(addr),
      .Data   (data_b),
      .read   (rd),
      .write  (wr),
      .Frame  (frame_b),
      .Ready  (ready_b)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   function automatic vec_t mk(input bit s, input bit w, input logic [31:0] a, input int nb,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
      vec_t v;
      v.sel  = s;
      v.wr   = w;
      v.addr = a;
      v.nb   = nb;
      v.d    = {d3, d2, d1, d0};
      v.lat  = s ? 1 : 2;  // WAIT_STATES + 1
      return v;
   endfunction

   function automatic logic rdy();
      return sel ? ready_b : ready_a;
   endfunction

   // Undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
   function automatic bit released();
      return $isunknown(data_in) || (data_in == 32'h0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic chk_rel(input string name);
      n_chk++;
      if (released()) n_pass++;
      else $display("FAIL %s: Data got %h, required Z", name, data_in);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frame(input logic v);
      if (sel) frame_b = v;
      else frame_a = v;
   endtask

   task automatic xfer(input bit is_wr, input logic [31:0] a, input int nb,
                       input logic [3:0][31:0] d, input int lat, input string tag);
      int beats;
      int t;
      int gap;
      gap    = sel ? 1 : 2;
      addr   = a;
      rd     = !is_wr;
      wr     = is_wr;
      drv_en = 1'b0;
      set_frame(1'b0);
      beats  = 0;
      t      = 0;
      while (beats < nb && t < 40) begin
         cyc();
         t++;
         rd   = 1'b0;
         wr   = 1'b0;
         addr = 32'hFFFF_FFFF;
         if (rdy()) begin
            bt[beats] = t;
            if (beats == nb - 1) set_frame(1'b1);
            drv_en = is_wr;
            drv    = d[beats];
            @(negedge clk);
            rbuf[beats] = data_in;
            beats++;
         end else begin
            drv_en = 1'b0;
         end
      end
      chk({tag, "-beats"}, beats, nb);
      cyc();
      drv_en = 1'b0;
      chk({tag, "-no-extra-ready"}, {31'b0, rdy()}, 32'd0);
      for (int k = 0; k < beats; k++) begin
         if (k == 0) chk({tag, "-first-latency"}, bt[0], lat);
         else chk($sformatf("%s-gap%0d", tag, k), bt[k] - bt[k-1], gap);
         if (!is_wr) chk($sformatf("%s-rdata%0d", tag, k), rbuf[k], d[k]);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      sel = v.sel;
      xfer(v.wr, v.addr, v.nb, v.d, v.lat, tag);
   endtask

   task automatic miss_seq(input bit r, input bit w, input logic [31:0] a, input bit drive,
                           input string tag);
      int seen;
      int bad;
      seen   = 0;
      bad    = 0;
      addr   = a;
      rd     = r;
      wr     = w;
      drv    = 32'h1111_1111;
      drv_en = drive;
      set_frame(1'b0);
      repeat (4) begin
         cyc();
         addr = 32'h0000_1004;  // a hit address while draining must not be claimed
         rd   = 1'b1;
         wr   = 1'b0;
         @(negedge clk);
         if (rdy()) seen++;
         if (!drive && !released()) bad++;
      end
      chk({tag, "-no-ready"}, seen, 0);
      if (!drive) chk({tag, "-data-z-cycles"}, bad, 0);
      cyc();
      set_frame(1'b1);
      rd     = 1'b0;
      drv_en = 1'b0;
      cyc();
      chk({tag, "-idle-after"}, {31'b0, rdy()}, 32'd0);
   endtask

   initial begin
      vecs[0]  = mk(0, 1, 32'h1004, 1, 32'hDEAD_BEEF, 0, 0, 0);
      vecs[1]  = mk(0, 0, 32'h1004, 1, 32'hDEAD_BEEF, 0, 0, 0);
      vecs[2]  = mk(1, 1, 32'h10FE, 4, 1, 2, 3, 4);
      vecs[3]  = mk(1, 0, 32'h10FE, 4, 1, 2, 3, 4);
      vecs[4]  = mk(1, 0, 32'h1000, 2, 3, 4, 0, 0);
      vecs[5]  = mk(0, 1, 32'h1005, 2, 32'h1234_5678, 32'h0BAD_F00D, 0, 0);
      vecs[6]  = mk(0, 0, 32'h1004, 3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D, 0);
      vecs[7]  = mk(0, 1, 32'h1010, 1, 0, 0, 0, 0);
      vecs[8]  = mk(0, 1, 32'h10FF, 2, 32'hCAFE_0001, 32'hCAFE_0002, 0, 0);
      vecs[9]  = mk(0, 0, 32'h1000, 1, 32'hCAFE_0002, 0, 0, 0);
      vecs[10] = mk(0, 0, 32'h10FF, 1, 32'hCAFE_0001, 0, 0, 0);

      rst     = 1'b1;
      addr    = '0;
      rd      = 1'b0;
      wr      = 1'b0;
      frame_a = 1'b1;
      frame_b = 1'b1;
      drv     = '0;
      drv_en  = 1'b0;
      sel     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset-ready-ws1", {31'b0, ready_a}, 32'd0);
      chk("reset-ready-ws0", {31'b0, ready_b}, 32'd0);
      chk_rel("reset-data-ws1");
      sel = 1'b1;
      chk_rel("reset-data-ws0");
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      sel = 1'b0;
      miss_seq(1, 0, 32'h2000, 0, "miss-2000");
      run_vec(mk(0, 0, 32'h1004, 1, 32'hDEAD_BEEF, 0, 0, 0), "after-miss");
      miss_seq(1, 1, 32'h1000, 1, "rd-and-wr");
      run_vec(mk(0, 0, 32'h1000, 1, 32'hCAFE_0002, 0, 0, 0), "rdwr-unchanged");
      miss_seq(0, 1, 32'h0FFF, 0, "miss-below");
      miss_seq(1, 0, 32'h1100, 0, "miss-above");
      sel = 1'b1;
      miss_seq(1, 0, 32'h2000, 0, "miss-ws0");
      run_vec(mk(1, 0, 32'h10FF, 1, 2, 0, 0, 0), "ws0-after-miss");

      // Frame rises during the wait of beat 2: that beat completes and is the last.
      sel     = 1'b0;
      addr    = 32'h1004;
      rd      = 1'b1;
      frame_a = 1'b0;
      cyc();
      rd = 1'b0;
      chk("abort-wait1", {31'b0, ready_a}, 32'd0);
      cyc();
      chk("abort-beat1-ready", {31'b0, ready_a}, 32'd1);
      @(negedge clk);
      chk("abort-beat1-data", data_in, 32'hDEAD_BEEF);
      cyc();
      chk("abort-wait2", {31'b0, ready_a}, 32'd0);
      frame_a = 1'b1;
      cyc();
      chk("abort-beat2-ready", {31'b0, ready_a}, 32'd1);
      @(negedge clk);
      chk("abort-beat2-data", data_in, 32'h1234_5678);
      begin
         int extra = 0;
         repeat (4) begin
            cyc();
            if (ready_a) extra++;
         end
         chk("abort-no-third-beat", extra, 0);
      end

      // Reset during the wait of a write beat: nothing committed, target back to idle.
      addr    = 32'h1010;
      wr      = 1'b1;
      frame_a = 1'b0;
      drv     = 32'hAAAA_5555;
      drv_en  = 1'b1;
      cyc();
      wr  = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst-wait-ready", {31'b0, ready_a}, 32'd0);
      drv_en = 1'b0;
      #1;
      chk_rel("rst-wait-data");
      @(posedge clk);
      #1;
      rst     = 1'b0;
      frame_a = 1'b1;
      cyc();
      run_vec(mk(0, 0, 32'h1010, 1, 0, 0, 0, 0), "rst-word-kept");

      // Reset during a read beat drops Ready and releases Data at once.
      addr    = 32'h1004;
      rd      = 1'b1;
      frame_a = 1'b0;
      cyc();
      rd = 1'b0;
      cyc();
      chk("rst-beat-ready-before", {31'b0, ready_a}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst-beat-ready", {31'b0, ready_a}, 32'd0);
      chk_rel("rst-beat-data");
      @(posedge clk);
      #1;
      rst     = 1'b0;
      frame_a = 1'b1;
      cyc();
      run_vec(mk(0, 0, 32'h1005, 1, 32'h1234_5678, 0, 0, 0), "after-rst-read");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
